// File: rtl/data_mem_responder.sv
// Load/store responder: accepts one request, then ready (and err) pulses LATENCY+1 cycles later.
// No backpressure: requests are sampled only in IDLE, and inputs are ignored while an access is in flight.
module data_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] adr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic                r_wr;
  logic                r_err;
  logic [ADDR_W-1:0]   r_idx;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic [31:0]         r_mem [2**ADDR_W];

  logic                w_req;
  logic                w_req_err;
  logic                w_resp;
  logic                w_good_rd;
  logic                w_good_wr;
  logic                w_unused_adr;

  assign w_req        = mem_read | mem_write;
  assign w_req_err    = (adr[1:0] != 2'b00) | (mem_read & mem_write);
  // Gating with rst makes a reset in the RESP cycle suppress the pulse and the commit.
  assign w_resp       = (r_state == RESP) && !rst;
  assign w_good_rd    = w_resp && !r_wr && !r_err;
  assign w_good_wr    = w_resp && r_wr && !r_err;
  assign w_unused_adr = ^adr[31:ADDR_W+2];

  assign ready     = w_resp;
  assign err       = w_resp && r_err;
  assign read_data = w_good_rd ? r_mem[r_idx] : r_rdata;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req) w_next = (LATENCY > 0) ? WAIT : RESP;
      WAIT:    if (r_cnt == 4'd0) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      if (r_state == IDLE && w_req) begin
        r_cnt   <= LAT_M1;
        r_wr    <= mem_write;
        r_err   <= w_req_err;
        r_idx   <= adr[ADDR_W+1:2];
        r_wdata <= write_data;
      end else if (r_state == WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_good_rd) r_rdata <= r_mem[r_idx];
    end
  end

  // Array has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (w_good_wr) r_mem[r_idx] <= r_wdata;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Drives a LATENCY=0 and a LATENCY=2 responder and checks them against a word-array memory model.
module tb_data_mem_responder;

  logic        clk;
  logic        rst  [2];
  logic        rd   [2];
  logic        wr   [2];
  logic [31:0] adr  [2];
  logic [31:0] wd   [2];
  logic [31:0] rdat [2];
  logic        rdy  [2];
  logic        er   [2];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          LAT [2] = '{0, 2};

  logic [31:0] mdl   [2][1024];
  bit          known [2][1024];
  logic [31:0] rdm   [2];
  bit          rdk   [2];

  data_mem_responder #(.ADDR_W(10), .LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst[0]), .mem_read(rd[0]), .mem_write(wr[0]), .adr(adr[0]),
    .write_data(wd[0]), .read_data(rdat[0]), .ready(rdy[0]), .err(er[0]));

  data_mem_responder #(.ADDR_W(10), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst[1]), .mem_read(rd[1]), .mem_write(wr[1]), .adr(adr[1]),
    .write_data(wd[1]), .read_data(rdat[1]), .ready(rdy[1]), .err(er[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs(input int i);
    rd[i] = 1'b0; wr[i] = 1'b0; adr[i] = 32'd0; wd[i] = 32'd0;
  endtask

  // One request presented for a single IDLE cycle; returns in the ready cycle.
  task automatic do_req(input int i, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
    bit       exp_err;
    int       idx;
    int       got;
    got     = 0;
    exp_err = (a[1:0] != 2'b00) || (r && w);
    idx     = int'(a[11:2]);
    @(posedge clk); #1;
    rd[i] = r; wr[i] = w; adr[i] = a; wd[i] = d;
    for (int k = 1; k <= LAT[i] + 4; k++) begin
      @(posedge clk); #1;
      if (rdy[i]) begin
        got = k;
        break;
      end
      if (k < LAT[i] + 1) begin
        rd[i] = 1'($urandom); wr[i] = 1'($urandom); adr[i] = $urandom; wd[i] = $urandom;
      end else begin
        idle_inputs(i);
      end
    end
    chk($sformatf("latency[L%0d]", LAT[i]), got, LAT[i] + 1);
    chk($sformatf("err[L%0d a=%h]", LAT[i], a), {31'd0, er[i]}, {31'd0, exp_err});
    if (!exp_err && r) begin
      if (known[i][idx]) chk($sformatf("rdata[L%0d a=%h]", LAT[i], a), rdat[i], mdl[i][idx]);
      rdm[i] = mdl[i][idx];
      rdk[i] = known[i][idx];
    end else if (rdk[i]) begin
      chk($sformatf("rdhold[L%0d a=%h]", LAT[i], a), rdat[i], rdm[i]);
    end
    if (!exp_err && w) begin
      mdl[i][idx]   = d;
      known[i][idx] = 1'b1;
    end
    idle_inputs(i);
  endtask

  task automatic do_reset(input int i);
    @(posedge clk); #1;
    rst[i] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_ready", {31'd0, rdy[i]}, 32'd0);
    chk("reset_err", {31'd0, er[i]}, 32'd0);
    chk("reset_rdata", rdat[i], 32'd0);
    rst[i] = 1'b0;
    rdm[i] = 32'd0;
    rdk[i] = 1'b1;
  endtask

  task automatic rand_ops(input int i, input int n);
    logic [31:0] a;
    int          op;
    for (int j = 0; j < n; j++) begin
      a       = $urandom;
      a[11:2] = 10'($urandom_range(0, 15));
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      op = $urandom_range(0, 9);
      do_req(i, op <= 4, op == 0 || op >= 5, a, $urandom);
    end
  endtask

  initial begin : main
    bit saw_rdy;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0;
      idle_inputs(i);
      rdk[i] = 1'b0;
      for (int w = 0; w < 1024; w++) known[i][w] = 1'b0;
    end

    // LATENCY=2 instance: directed cases
    do_reset(1);
    do_req(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    do_req(1, 1'b0, 1'b1, 32'h40, 32'h12345678);
    do_req(1, 1'b1, 1'b0, 32'h40, 32'h0);
    do_req(1, 1'b0, 1'b1, 32'h0, 32'hA5A5A5A5);
    do_req(1, 1'b1, 1'b0, 32'h1000, 32'h0);
    do_req(1, 1'b1, 1'b0, 32'h42, 32'h0);
    do_req(1, 1'b1, 1'b1, 32'h40, 32'h0BADF00D);
    do_req(1, 1'b1, 1'b0, 32'h40, 32'h0);
    do_req(1, 1'b0, 1'b1, 32'h80, 32'h11112222);

    // reset while the store sits in WAIT
    @(posedge clk); #1;
    wr[1] = 1'b1; adr[1] = 32'h80; wd[1] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    idle_inputs(1);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    rdm[1] = 32'd0;
    saw_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (rdy[1]) saw_rdy = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort_no_ready", {31'd0, saw_rdy}, 32'd0);
    do_req(1, 1'b1, 1'b0, 32'h80, 32'h0);
    rand_ops(1, 40);

    // LATENCY=0 instance
    do_reset(0);
    for (int w = 0; w < 8; w++) do_req(0, 1'b0, 1'b1, 32'(w * 4), $urandom);
    @(posedge clk); #1;
    for (int w = 0; w < 8; w++) begin
      chk($sformatf("b2b_idle[%0d]", w), {31'd0, rdy[0]}, 32'd0);
      rd[0] = 1'b1; wr[0] = 1'b0; adr[0] = {$urandom_range(0, 255), 10'(w), 2'b00};
      @(posedge clk); #1;
      chk($sformatf("b2b_ready[%0d]", w), {31'd0, rdy[0]}, 32'd1);
      chk($sformatf("b2b_rdata[%0d]", w), rdat[0], mdl[0][w]);
      adr[0] = $urandom; wr[0] = 1'($urandom); wd[0] = $urandom;
      @(posedge clk); #1;
      wr[0] = 1'b0;
    end
    rdm[0] = mdl[0][7];
    idle_inputs(0);
    for (int w = 0; w < 8; w++) do_req(0, 1'b1, 1'b0, 32'(w * 4), 32'h0);
    rand_ops(0, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
